// File: rtl/mem_max_scanner_if.sv
// Memory port between the scanner (master) and the AW x DW data memory (slave).
// Read data is combinational from mem_adr; writes land on the next rising clk.
interface mem_max_scanner_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_adr, mem_wdata, mem_wen, input mem_rdata);
  modport slave  (input mem_adr, mem_wdata, mem_wen, output mem_rdata);
endinterface

// File: rtl/mem_max_scanner.sv
// Sequentially scans count words from base, tracking the unsigned maximum and its first offset.
// Define MAX_WRITEBACK_EN to write the maximum back to word base+count after each non-empty scan.
module mem_max_scanner #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AW-1:0]            base,
  input  logic [AW:0]              count,
  mem_max_scanner_if.master        mem,
  output logic                     busy,
  output logic                     done,
  output logic [DW-1:0]            max_val,
  output logic [AW-1:0]            max_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

  state_t        state;
  logic [AW-1:0] base_q;
  logic [AW:0]   count_q;
  logic [AW:0]   i;
  logic [AW:0]   i_nxt;
  logic [AW-1:0] adr_q;
  logic          last;

  assign i_nxt = i + (AW+1)'(1);
  assign last  = (i == count_q - (AW+1)'(1));

  assign mem.mem_adr   = adr_q;
  assign mem.mem_wdata = max_val;

`ifdef MAX_WRITEBACK_EN
  logic wen_q;
  assign mem.mem_wen = wen_q;
`else
  assign mem.mem_wen = 1'b0;
`endif

  // NOTE: every register here is assigned with <= so all updates within one edge
  // see the pre-edge values; blocking assignments would make order matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      i       <= '0;
      adr_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      max_val <= '0;
      max_idx <= '0;
`ifdef MAX_WRITEBACK_EN
      wen_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MAX_WRITEBACK_EN
      wen_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base;
            count_q <= count;
            i       <= '0;
            adr_q   <= base;
            max_val <= '0;
            max_idx <= '0;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
            end
          end
        end

        SCAN: begin
          // Strict compare keeps the earliest offset on ties.
          if (i == '0 || mem.mem_rdata > max_val) begin
            max_val <= mem.mem_rdata;
            max_idx <= i[AW-1:0];
          end
          i <= i_nxt;
          if (last) begin
`ifdef MAX_WRITEBACK_EN
            state <= WB;
            adr_q <= base_q + count_q[AW-1:0];
            wen_q <= 1'b1;
`else
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end else begin
            adr_q <= base_q + i_nxt[AW-1:0];
          end
        end

`ifdef MAX_WRITEBACK_EN
        WB: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`endif

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
